// File: rtl/router_port_arbiter.sv
// ---------------------------------------------------------------------------
// router_port_arbiter
//
// Shares one router output port among NUM_REQ requesters (0 = local NI,
// 1 = north, 2 = south, 3 = east, 4 = west). A round-robin arbiter picks one
// valid requester per cycle and the winning packet is captured in a
// single-entry output register. Simultaneous packets aimed at the same port
// are serialised instead of being OR-combined into garbage.
//
// Ports
//   i_clk     : clock
//   i_arst_n  : asynchronous active-low reset; deassertion is expected to be
//               synchronous to i_clk (done by the reset controller upstream)
//   i_valid   : per-requester packet valid
//   i_packet  : flattened packets, requester k at [k*PACKET_WIDTH +: PACKET_WIDTH]
//   o_ready   : per-requester accept (combinational, at most one bit set)
//   o_valid   : output register holds a packet
//   o_packet  : registered output packet
//   i_ready   : downstream accepts o_packet this cycle
//   o_grant   : one-hot of the requester whose packet sits in the register,
//               all zeros when the register is empty
// ---------------------------------------------------------------------------

package pa_noc;
  // Width of one APB-over-NoC packet as carried between routers.
  localparam int APB_PACKET_WIDTH = 64;
endpackage

module router_port_arbiter #(
  parameter int NUM_REQ = 5
) (
  input  logic                                        i_clk,
  input  logic                                        i_arst_n,
  input  logic [NUM_REQ-1:0]                          i_valid,
  input  logic [NUM_REQ*pa_noc::APB_PACKET_WIDTH-1:0] i_packet,
  output logic [NUM_REQ-1:0]                          o_ready,
  output logic                                        o_valid,
  output logic [pa_noc::APB_PACKET_WIDTH-1:0]         o_packet,
  input  logic                                        i_ready,
  output logic [NUM_REQ-1:0]                          o_grant
);

  localparam int PACKET_WIDTH = pa_noc::APB_PACKET_WIDTH;
  localparam int PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                    state_q;
  state_e                    state_d;

  logic [PTR_W-1:0]          prioPtr_q;
  logic [PTR_W-1:0]          prioPtr_d;
  logic [PACKET_WIDTH-1:0]   packet_q;
  logic [PACKET_WIDTH-1:0]   packet_d;
  logic [NUM_REQ-1:0]        grant_q;
  logic [NUM_REQ-1:0]        grant_d;

  logic [NUM_REQ-1:0]        sel;
  logic [PTR_W-1:0]          winIdx;
  logic                      winFound;
  int                        scanIdx;
  logic [PACKET_WIDTH-1:0]   winPacket;
  logic                      canLoad;
  logic                      xferIn;
  logic                      xferOut;

  // Round-robin scan: start at the priority pointer and walk upwards,
  // wrapping from NUM_REQ-1 back to 0. The first valid requester wins.
  always_comb begin
    sel      = '0;
    winIdx   = '0;
    winFound = 1'b0;
    scanIdx  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scanIdx = int'(prioPtr_q) + off;
      if (scanIdx >= NUM_REQ) begin
        scanIdx = scanIdx - NUM_REQ;
      end
      if (!winFound && i_valid[scanIdx]) begin
        winFound     = 1'b1;
        sel[scanIdx] = 1'b1;
        winIdx       = PTR_W'(scanIdx);
      end
    end
  end

  // Winner packet select as a one-hot AND-OR; sel is never multi-hot, so
  // this is equivalent to an indexed mux without a variable part-select.
  always_comb begin
    winPacket = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      winPacket = winPacket
                | ({PACKET_WIDTH{sel[k]}} & i_packet[k*PACKET_WIDTH +: PACKET_WIDTH]);
    end
  end

  // FSM state register. EMPTY/FULL mirrors whether the output register
  // currently holds a packet.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. A new packet always wins over a drain so that a
  // simultaneous out+in keeps the register full (one packet per cycle).
  always_comb begin
    state_d = state_q;
    if (xferIn) begin
      state_d = FULL;
    end else if (xferOut) begin
      state_d = EMPTY;
    end
  end

  // FSM outputs and handshake. The register may load when it is empty or
  // being drained this cycle. o_ready is forced low while reset is held so
  // no requester believes a packet was taken during reset.
  always_comb begin
    o_valid = (state_q == FULL);
    canLoad = !o_valid || i_ready;
    o_ready = '0;
    if (i_arst_n && canLoad) begin
      o_ready = sel;
    end
    xferIn  = |(o_ready & i_valid);
    xferOut = o_valid && i_ready;
  end

  // Datapath next values. The pointer only moves on a transfer in, to the
  // slot just after the winner, so a stalled cycle never reshuffles priority.
  // On a drain without reload the packet is left as-is; only the grant
  // clears to show the register is empty.
  always_comb begin
    packet_d  = packet_q;
    grant_d   = grant_q;
    prioPtr_d = prioPtr_q;
    if (xferIn) begin
      packet_d = winPacket;
      grant_d  = sel;
      if (winIdx == LAST_IDX) begin
        prioPtr_d = '0;
      end else begin
        prioPtr_d = winIdx + PTR_W'(1);
      end
    end else if (xferOut) begin
      grant_d = '0;
    end
  end

  // Datapath registers. Reset discards any buffered packet and returns the
  // priority to requester 0.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      packet_q  <= '0;
      grant_q   <= '0;
      prioPtr_q <= '0;
    end else begin
      packet_q  <= packet_d;
      grant_q   <= grant_d;
      prioPtr_q <= prioPtr_d;
    end
  end

  assign o_packet = packet_q;
  assign o_grant  = grant_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_router_port_arbiter
//
// Directed, self-checking bench for router_port_arbiter with NUM_REQ = 5.
// Each task drives one scenario and compares the outputs against values
// worked out by hand from the arbitration rules. Inputs change 1 ns after
// the rising edge; outputs are sampled away from the edge.
// ---------------------------------------------------------------------------

module tb_router_port_arbiter;

  localparam int NUM = 5;
  localparam int PW  = pa_noc::APB_PACKET_WIDTH;

  logic                clk;
  logic                arstN;
  logic [NUM-1:0]      validIn;
  logic [NUM*PW-1:0]   packetBus;
  logic [NUM-1:0]      oReady;
  logic                oValid;
  logic [PW-1:0]       oPacket;
  logic                readyIn;
  logic [NUM-1:0]      oGrant;

  int checks;
  int errors;

  router_port_arbiter #(
    .NUM_REQ (NUM)
  ) dut (
    .i_clk    (clk),
    .i_arst_n (arstN),
    .i_valid  (validIn),
    .i_packet (packetBus),
    .o_ready  (oReady),
    .o_valid  (oValid),
    .o_packet (oPacket),
    .i_ready  (readyIn),
    .o_grant  (oGrant)
  );

  // Free-running clock, rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requester-side rule monitor: a requester that was valid but not accepted
  // must keep valid high and its packet unchanged at the next edge.
  logic [NUM-1:0]    prevValid;
  logic [NUM-1:0]    prevReady;
  logic [NUM*PW-1:0] prevBus;
  logic              armed;

  always @(posedge clk) begin
    if (armed === 1'b1 && arstN === 1'b1) begin
      for (int k = 0; k < NUM; k++) begin
        if (prevValid[k] && !prevReady[k]) begin
          assert (validIn[k] && packetBus[k*PW +: PW] == prevBus[k*PW +: PW])
            else $error("[TB] requester %0d dropped valid or changed packet while waiting", k);
        end
      end
    end
    prevValid <= validIn;
    prevReady <= oReady;
    prevBus   <= packetBus;
    armed     <= arstN;
  end

  function automatic logic [NUM-1:0] oneHot(input int k);
    logic [NUM-1:0] r;
    r    = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [PW-1:0] pktOf(input int k);
    logic [63:0] base;
    base = 64'hF00D_0000_0000_00A0 + 64'(k);
    return PW'(base);
  endfunction

  task automatic setPkt(input int k, input logic [PW-1:0] v);
    packetBus[k*PW +: PW] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges, then release it on a falling edge so the
  // deassertion is well away from any rising edge.
  task automatic doReset();
    arstN     = 1'b0;
    validIn   = '0;
    readyIn   = 1'b0;
    packetBus = '0;
    repeat (2) tick();
    @(negedge clk);
    arstN = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    arstN     = 1'b0;
    validIn   = 5'b11111;
    readyIn   = 1'b1;
    packetBus = '0;
    for (int k = 0; k < NUM; k++) setPkt(k, pktOf(k));
    repeat (2) tick();
    checks++;
    if (oValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid got=%b exp=0", oValid);
    end
    checks++;
    if (oPacket !== '0) begin
      errors++;
      $display("[TB] FAIL reset_packet got=%h exp=0", oPacket);
    end
    checks++;
    if (oGrant !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_grant got=%b exp=00000", oGrant);
    end
    checks++;
    if (oReady !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_ready got=%b exp=00000", oReady);
    end
  endtask

  task automatic test_single();
    doReset();
    validIn = 5'b00100;
    setPkt(2, PW'(64'hA5));
    readyIn = 1'b1;
    #1;
    checks++;
    if (oReady !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL single_ready got=%b exp=00100", oReady);
    end
    tick();
    validIn = '0;
    checks++;
    if (oValid !== 1'b1 || oPacket !== PW'(64'hA5) || oGrant !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL single_load got v=%b p=%h g=%b exp v=1 p=a5 g=00100",
               oValid, oPacket, oGrant);
    end
    tick();
    checks++;
    if (oValid !== 1'b0 || oGrant !== 5'b00000 || oPacket !== PW'(64'hA5)) begin
      errors++;
      $display("[TB] FAIL single_drain got v=%b p=%h g=%b exp v=0 p=a5 g=00000",
               oValid, oPacket, oGrant);
    end
  endtask

  task automatic test_round_robin();
    int order[7] = '{0, 1, 2, 3, 4, 0, 1};
    doReset();
    for (int k = 0; k < NUM; k++) setPkt(k, pktOf(k));
    validIn = 5'b11111;
    readyIn = 1'b1;
    #1;
    checks++;
    if (oReady !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL rr_first_ready got=%b exp=00001", oReady);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (oValid !== 1'b1 || oGrant !== oneHot(order[i])) begin
        errors++;
        $display("[TB] FAIL rr_grant[%0d] got v=%b g=%b exp v=1 g=%b",
                 i, oValid, oGrant, oneHot(order[i]));
      end
      checks++;
      if (oPacket !== pktOf(order[i])) begin
        errors++;
        $display("[TB] FAIL rr_packet[%0d] got=%h exp=%h", i, oPacket, pktOf(order[i]));
      end
      checks++;
      if (oReady !== oneHot((order[i] + 1) % NUM)) begin
        errors++;
        $display("[TB] FAIL rr_ready[%0d] got=%b exp=%b",
                 i, oReady, oneHot((order[i] + 1) % NUM));
      end
    end
  endtask

  task automatic test_backpressure();
    doReset();
    setPkt(3, PW'(64'h33));
    setPkt(1, PW'(64'h11));
    validIn = 5'b01000;
    readyIn = 1'b0;
    #1;
    checks++;
    if (oReady !== 5'b01000) begin
      errors++;
      $display("[TB] FAIL bp_load_ready got=%b exp=01000", oReady);
    end
    tick();
    validIn = 5'b00010;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (oValid !== 1'b1 || oPacket !== PW'(64'h33) || oGrant !== 5'b01000) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d] got v=%b p=%h g=%b exp v=1 p=33 g=01000",
                 c, oValid, oPacket, oGrant);
      end
      checks++;
      if (oReady !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL bp_stall_ready[%0d] got=%b exp=00000", c, oReady);
      end
      tick();
    end
    readyIn = 1'b1;
    #1;
    checks++;
    if (oReady !== 5'b00010) begin
      errors++;
      $display("[TB] FAIL bp_release_ready got=%b exp=00010", oReady);
    end
    tick();
    validIn = '0;
    checks++;
    if (oValid !== 1'b1 || oPacket !== PW'(64'h11) || oGrant !== 5'b00010) begin
      errors++;
      $display("[TB] FAIL bp_next got v=%b p=%h g=%b exp v=1 p=11 g=00010",
               oValid, oPacket, oGrant);
    end
    tick();
    checks++;
    if (oValid !== 1'b0 || oGrant !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL bp_empty got v=%b g=%b exp v=0 g=00000", oValid, oGrant);
    end
  endtask

  task automatic test_wraparound();
    doReset();
    for (int k = 0; k < NUM; k++) setPkt(k, pktOf(k));
    readyIn = 1'b1;
    validIn = 5'b01000;
    tick();
    validIn = 5'b00011;
    #1;
    checks++;
    if (oReady !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL wrap_ready0 got=%b exp=00001", oReady);
    end
    tick();
    validIn = 5'b00010;
    #1;
    checks++;
    if (oGrant !== 5'b00001 || oPacket !== pktOf(0) || oReady !== 5'b00010) begin
      errors++;
      $display("[TB] FAIL wrap_first got g=%b p=%h r=%b exp g=00001 p=%h r=00010",
               oGrant, oPacket, oReady, pktOf(0));
    end
    tick();
    validIn = '0;
    checks++;
    if (oGrant !== 5'b00010 || oPacket !== pktOf(1)) begin
      errors++;
      $display("[TB] FAIL wrap_second got g=%b p=%h exp g=00010 p=%h",
               oGrant, oPacket, pktOf(1));
    end
  endtask

  task automatic test_fairness();
    doReset();
    for (int k = 0; k < NUM; k++) setPkt(k, pktOf(k));
    readyIn = 1'b1;
    validIn = 5'b00001;
    tick();
    validIn = 5'b10001;
    #1;
    checks++;
    if (oGrant !== 5'b00001 || oReady !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL fair_pick4 got g=%b r=%b exp g=00001 r=10000", oGrant, oReady);
    end
    tick();
    validIn = 5'b00001;
    #1;
    checks++;
    if (oGrant !== 5'b10000 || oPacket !== pktOf(4)) begin
      errors++;
      $display("[TB] FAIL fair_grant4 got g=%b p=%h exp g=10000 p=%h",
               oGrant, oPacket, pktOf(4));
    end
    tick();
    checks++;
    if (oGrant !== 5'b00001 || oValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fair_back0 got g=%b v=%b exp g=00001 v=1", oGrant, oValid);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    for (int k = 0; k < NUM; k++) setPkt(k, pktOf(k));
    validIn = 5'b00100;
    readyIn = 1'b0;
    tick();
    validIn = '0;
    checks++;
    if (oValid !== 1'b1 || oGrant !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL mid_loaded got v=%b g=%b exp v=1 g=00100", oValid, oGrant);
    end
    #2;
    arstN = 1'b0;
    #1;
    checks++;
    if (oValid !== 1'b0 || oPacket !== '0 || oGrant !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL mid_async_clear got v=%b p=%h g=%b exp v=0 p=0 g=00000",
               oValid, oPacket, oGrant);
    end
    validIn = 5'b11111;
    readyIn = 1'b1;
    #1;
    checks++;
    if (oReady !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL mid_ready_in_reset got=%b exp=00000", oReady);
    end
    tick();
    @(negedge clk);
    arstN = 1'b1;
    #1;
    checks++;
    if (oValid !== 1'b0 || oReady !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL mid_release got v=%b r=%b exp v=0 r=00001", oValid, oReady);
    end
    tick();
    checks++;
    if (oValid !== 1'b1 || oGrant !== 5'b00001 || oPacket !== pktOf(0)) begin
      errors++;
      $display("[TB] FAIL mid_first_grant got v=%b g=%b p=%h exp v=1 g=00001 p=%h",
               oValid, oGrant, oPacket, pktOf(0));
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    arstN     = 1'b0;
    validIn   = '0;
    readyIn   = 1'b0;
    packetBus = '0;
    $display("[TB] router_port_arbiter directed tests");
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wraparound();
    test_fairness();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_port_arbiter.md
Name: router_port_arbiter

Overview:
- Round-robin arbiter plus single-entry output register for one router output port.
- Shares that port among up to NUM_REQ requesters: local NI, north, south, east, west.
- Replaces the current OR-combining of packets, so simultaneous packets to one port are serialised, not corrupted.
- One instance per router output port (o_north, o_south, o_east, o_west, o_apbPacket); valid/ready handshake on both sides.

Parameters:
- NUM_REQ, 5, number of requesters; index 0=local NI, 1=north, 2=south, 3=east, 4=west.
- PACKET_WIDTH, pa_noc::APB_PACKET_WIDTH (localparam, not overridable), packet width in bits.

Ports:
- i_clk  input  1  clock.
- i_arst_n  input  1  asynchronous active-low reset.
- i_valid  input  NUM_REQ  per-requester packet valid.
- i_packet  input  NUM_REQ*PACKET_WIDTH  flattened packets; requester k occupies bits [k*PACKET_WIDTH +: PACKET_WIDTH].
- o_ready  output  NUM_REQ  per-requester accept; combinational.
- o_valid  output  1  output register holds a packet.
- o_packet  output  PACKET_WIDTH  registered output packet.
- i_ready  input  1  downstream router/NI accepts o_packet.
- o_grant  output  NUM_REQ  registered one-hot of the requester whose packet is in the output register; '0 when empty.

Behaviour:
- Reset (i_arst_n low, async assert, sync deassert):
  - o_valid=0, o_packet='0, o_grant='0.
  - Priority pointer = 0, so requester 0 has highest priority.
  - o_ready is combinationally 0 while in reset.
- State: EMPTY (o_valid=0) or FULL (o_valid=1).
- Load enable: can_load = !o_valid | i_ready.
- Arbitration, combinational, each cycle:
  - Scan i_valid starting at the pointer, wrapping from NUM_REQ-1 to 0.
  - The first set bit is the winner; sel is one-hot of the winner, '0 if none.
- o_ready[k] = sel[k] & can_load.
  - At most one bit set.
  - Never set for a requester with i_valid=0.
- Transfer in: i_valid[k] & o_ready[k]. On the next edge:
  - o_packet <= that packet, o_valid <= 1, o_grant <= sel.
  - Pointer <= (k+1) mod NUM_REQ.
- Transfer out: o_valid & i_ready.
  - If no transfer in the same cycle: o_valid <= 0, o_grant <= '0; o_packet holds its old value.
- Simultaneous out and in: register reloads with the new packet. Throughput is 1 packet/cycle, no bubble.
- FULL with i_ready=0: o_packet, o_valid and o_grant stay stable; all o_ready=0.
- Pointer updates only on a transfer in. A stalled cycle never changes priority.
- Latency: a packet accepted at edge N is visible on o_packet after edge N.
- Requester rules:
  - Once i_valid[k] is asserted, hold i_packet[k] stable until o_ready[k].
  - Do not deassert i_valid[k] without a transfer.
  - Violations are undefined; a bench assertion flags them.
- Starvation bound: a continuously valid requester is granted within NUM_REQ transfers in.
- Packet content is not inspected; routing decode stays in the router.
- Reset mid-operation: any buffered packet is discarded, all state returns to reset values, and no o_valid pulse follows reset release.

Test Plan:
- Single request: i_valid=5'b00100, i_packet[2]=0x..A5, i_ready=1.
  - Required: o_ready=5'b00100 in the same cycle.
  - Next cycle: o_valid=1, o_packet=0x..A5, o_grant=5'b00100.
  - Cycle after: o_valid=0, o_grant='0.
- All requesters valid from reset, i_ready=1 constant:
  - Grant order 0,1,2,3,4,0,1; one packet out per cycle, no idle cycles.
- Backpressure: load requester 3, hold i_ready=0 for 4 cycles while requester 1 stays valid.
  - Required: o_packet, o_valid and o_grant stable; o_ready=0 throughout.
  - On i_ready=1 in the same cycle: o_ready[1]=1; the next cycle shows requester 1's packet.
- Wrap-around: pointer=4 after granting 3; i_valid=5'b00011.
  - Required: requester 0 is granted first, then requester 1.
- Fairness: requester 0 valid continuously, requester 4 asserts once.
  - Required: requester 4 is granted within 2 transfers and requester 0 is not granted twice in a row while 4 waits.
- Reset mid-operation: assert i_arst_n low while o_valid=1, asynchronously between edges.
  - Required: o_valid=0, o_packet='0 and o_grant='0 immediately.
  - After release with i_valid=5'b11111, requester 0 is granted first.
